// File: rtl/fib_sample_fifo_if.sv
// Wishbone slave window signals for the fibonacci sample FIFO.
// The master modport is the firmware side (the user-project bus);
// the slave modport is the capture block that answers it.
interface fib_sample_fifo_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i,
        output wbs_cyc_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_dat_i,
        output wbs_adr_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i,
        input  wbs_cyc_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_dat_i,
        input  wbs_adr_i,
        output wbs_ack_o,
        output wbs_dat_o
    );
endinterface

// File: rtl/fib_sample_fifo.sv
// Capture stage behind the fibonacci generator. The generator value is
// sampled into a small FIFO at a programmable decimation rate, firmware
// drains it through a Wishbone register window, and a level interrupt
// fires on a fill threshold or on overflow.
module fib_sample_fifo #(
    parameter int unsigned WIDTH        = 30,
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100
) (
    input  logic             wb_clk_i,
    input  logic             reset,
    fib_sample_fifo_if.slave wbs,
    input  logic [WIDTH-1:0] value_i,
    output logic             irq_o,
    output logic [3:0]       level_o
);

    localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  FULL_COUNT = 4'(DEPTH);

    localparam logic [4:0] ADR_STATUS = 5'h00;
    localparam logic [4:0] ADR_DATA   = 5'h04;
    localparam logic [4:0] ADR_CTRL   = 5'h08;
    localparam logic [4:0] ADR_CLEAR  = 5'h0C;
    localparam logic [4:0] ADR_THRESH = 5'h10;

    // Bus-facing registers
    logic        ack_q, ack_d;
    logic [31:0] datOut_q, datOut_d;

    // FIFO bookkeeping
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [3:0]       count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Control, threshold and decimation state
    logic        enable_q, enable_d;
    logic        irqEn_q, irqEn_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  thresh_q, thresh_d;
    logic        irq_q, irq_d;

    // Decoded per-cycle events
    logic        hit;
    logic        access;
    logic [4:0]  offset;
    logic        writeOk;
    logic        readAcc;
    logic        ctrlWr;
    logic        threshWr;
    logic        clearWr;
    logic        empty;
    logic        full;
    logic        sampleStrobe;
    logic        popReq;
    logic        pushOk;

    // Read-back words
    logic [31:0] headData;
    logic [31:0] statusWord;
    logic [31:0] ctrlWord;
    logic [31:0] readWord;

    logic        unusedBits;

    // Data bits that no register implements.
    assign unusedBits = ^{wbs.wbs_dat_i[31:24], wbs.wbs_dat_i[7:4]};

    // Decode the bus access and derive push/pop/clear events for this edge.
    always_comb begin
        hit          = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                       (wbs.wbs_adr_i[31:5] == BASE_ADDRESS[31:5]);
        access       = hit & ~ack_q;
        offset       = wbs.wbs_adr_i[4:0];
        writeOk      = access & wbs.wbs_we_i & (wbs.wbs_sel_i == 4'hF);
        readAcc      = access & ~wbs.wbs_we_i;
        ctrlWr       = writeOk & (offset == ADR_CTRL);
        threshWr     = writeOk & (offset == ADR_THRESH);
        clearWr      = writeOk & (offset == ADR_CLEAR);
        empty        = (count_q == 4'd0);
        full         = (count_q == FULL_COUNT);
        sampleStrobe = enable_q & (cnt_q == div_q);
        popReq       = readAcc & (offset == ADR_DATA) & ~empty;
        pushOk       = sampleStrobe & ~clearWr & (~full | popReq);
    end

    // Assemble the word returned for the addressed register.
    always_comb begin
        headData                = '0;
        headData[WIDTH-1:0]     = mem_q[rdPtr_q];
        statusWord              = {20'd0, count_q, 5'd0, overflow_q, full, empty};
        ctrlWord                = {8'd0, div_q, 6'd0, irqEn_q, enable_q};
        readWord                = '0;
        case (offset)
            ADR_STATUS: readWord = statusWord;
            ADR_DATA:   readWord = empty ? 32'd0 : headData;
            ADR_CTRL:   readWord = ctrlWord;
            ADR_THRESH: readWord = {28'd0, thresh_q};
            default:    readWord = '0;
        endcase
    end

    // FIFO pointers, fill count and sticky overflow; a clear beats a coincident push.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clearWr) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (popReq) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({pushOk, popReq})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
            if (sampleStrobe & full & ~popReq) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control/threshold writes and the decimation counter.
    always_comb begin
        enable_d = enable_q;
        irqEn_d  = irqEn_q;
        div_d    = div_q;
        thresh_d = thresh_q;
        cnt_d    = cnt_q;
        if (ctrlWr) begin
            enable_d = wbs.wbs_dat_i[0];
            irqEn_d  = wbs.wbs_dat_i[1];
            div_d    = wbs.wbs_dat_i[23:8];
        end
        if (threshWr) begin
            thresh_d = wbs.wbs_dat_i[3:0];
        end
        if (ctrlWr | ~enable_q) begin
            cnt_d = '0;
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Single-cycle ack pulse, held read data, and the registered interrupt.
    always_comb begin
        ack_d    = hit & ~ack_q;
        datOut_d = readAcc ? readWord : datOut_q;
        irq_d    = irqEn_q & (((thresh_q != 4'd0) & (count_q >= thresh_q)) | overflow_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            ack_q      <= 1'b0;
            datOut_q   <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b0;
            irqEn_q    <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            thresh_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            datOut_q   <= datOut_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
            irqEn_q    <= irqEn_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            thresh_q   <= thresh_d;
            irq_q      <= irq_d;
        end
    end

    // Sample storage; contents need no reset since the count gates visibility.
    always_ff @(posedge wb_clk_i) begin
        if (!reset && pushOk) begin
            mem_q[wrPtr_q] <= value_i;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = datOut_q;
    assign irq_o         = irq_q;
    assign level_o       = count_q;

endmodule

// File: tb/tb_fib_sample_fifo.sv
// Bench for fib_sample_fifo: register table, directed corner sequences,
// and randomized bus traffic checked every cycle against a queue-based
// reference model of the FIFO window.
module tb_fib_sample_fifo;

    localparam int          WIDTH = 30;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0100;

    localparam logic [4:0] OFF_STATUS = 5'h00;
    localparam logic [4:0] OFF_DATA   = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_CLEAR  = 5'h0C;
    localparam logic [4:0] OFF_THRESH = 5'h10;

    typedef struct {
        logic        we;
        logic [4:0]  off;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] expRd;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] valueIn;
    logic             irqO;
    logic [3:0]       levelO;
    bit               valueRandom;
    bit               modelOn;
    int               checks;
    int               errors;

    fib_sample_fifo_if wbBus();

    fib_sample_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .BASE_ADDRESS(BASE)
    ) dut (
        .wb_clk_i(clk),
        .reset(reset),
        .wbs(wbBus),
        .value_i(valueIn),
        .irq_o(irqO),
        .level_o(levelO)
    );

    always #5 clk = ~clk;

    // Generator stand-in: counts up, or random values in the random phase.
    always @(posedge clk) begin
        #2;
        if (valueRandom) valueIn = WIDTH'($urandom);
        else             valueIn = valueIn + 1'b1;
    end

    // Reference model state: a queue of captured samples plus config.
    logic [31:0] mq[$];
    bit          mOvf, mEn, mIrqEn, mAck, mIrq;
    int          mDiv, mThresh, mSince, mSize;
    logic [31:0] mDat;
    bit          mHit, mAcc, mWr, mRd, mSample, mPop, mClr, mIrqNext;
    logic [4:0]  mOff;

    // Model step: decide everything from pre-edge state, then update.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mOvf = 0; mEn = 0; mIrqEn = 0; mAck = 0; mIrq = 0;
            mDiv = 0; mThresh = 0; mSince = 0; mDat = '0;
        end else begin
            mHit     = wbBus.wbs_stb_i && wbBus.wbs_cyc_i && (wbBus.wbs_adr_i[31:5] == BASE[31:5]);
            mAcc     = mHit && !mAck;
            mOff     = wbBus.wbs_adr_i[4:0];
            mWr      = mAcc && wbBus.wbs_we_i && (wbBus.wbs_sel_i == 4'hF);
            mRd      = mAcc && !wbBus.wbs_we_i;
            mSize    = mq.size();
            mSample  = mEn && (((mSince + 1) % (mDiv + 1)) == 0);
            mPop     = mRd && (mOff == OFF_DATA) && (mSize != 0);
            mClr     = mWr && (mOff == OFF_CLEAR);
            mIrqNext = mIrqEn && (((mThresh != 0) && (mSize >= mThresh)) || mOvf);
            if (mRd) begin
                case (mOff)
                    OFF_STATUS: mDat = {20'd0, 4'(mSize), 5'd0, mOvf, (mSize == DEPTH), (mSize == 0)};
                    OFF_DATA:   mDat = (mSize != 0) ? mq[0] : 32'd0;
                    OFF_CTRL:   mDat = {8'd0, 16'(mDiv), 6'd0, mIrqEn, mEn};
                    OFF_THRESH: mDat = 32'(mThresh);
                    default:    mDat = 32'd0;
                endcase
            end
            if (mClr) begin
                mq.delete();
                mOvf = 0;
            end else begin
                if (mPop) void'(mq.pop_front());
                if (mSample) begin
                    if (mq.size() < DEPTH) mq.push_back(32'(valueIn));
                    else                   mOvf = 1;
                end
            end
            mSince = mSince + 1;
            if (mWr && mOff == OFF_CTRL) begin
                mEn    = wbBus.wbs_dat_i[0];
                mIrqEn = wbBus.wbs_dat_i[1];
                mDiv   = int'(wbBus.wbs_dat_i[23:8]);
                mSince = 0;
            end
            if (mWr && mOff == OFF_THRESH) mThresh = int'(wbBus.wbs_dat_i[3:0]);
            mAck = mHit && !mAck;
            mIrq = mIrqNext;
        end
    end

    // Compare every DUT output against the model away from the clock edge.
    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model ack", 32'(wbBus.wbs_ack_o), 32'(mAck));
            checkOutput("model dat", wbBus.wbs_dat_o, mDat);
            checkOutput("model irq", 32'(irqO), 32'(mIrq));
            checkOutput("model level", 32'(levelO), 32'(mq.size()));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus transfer, started at a negedge; returns read data, ack latency
    // and the generator value present at the acked edge.
    task automatic busXfer(input logic we, input logic [4:0] off, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rd, output int lat,
                           output logic [WIDTH-1:0] accVal);
        logic [WIDTH-1:0] cand;
        bit               done;
        wbBus.wbs_stb_i = 1'b1;
        wbBus.wbs_cyc_i = 1'b1;
        wbBus.wbs_we_i  = we;
        wbBus.wbs_sel_i = sel;
        wbBus.wbs_dat_i = dat;
        wbBus.wbs_adr_i = BASE | {27'd0, off};
        rd = '0; lat = 0; accVal = '0; done = 0;
        for (int i = 1; i <= 4 && !done; i++) begin
            cand = valueIn;
            @(negedge clk);
            if (wbBus.wbs_ack_o) begin
                done = 1; lat = i; rd = wbBus.wbs_dat_o; accVal = cand;
            end
        end
        wbBus.wbs_stb_i = 1'b0;
        wbBus.wbs_cyc_i = 1'b0;
        wbBus.wbs_we_i  = 1'b0;
        checkOutput("ack seen", 32'(done), 32'd1);
    endtask

    task automatic wbRead(input logic [4:0] off, output logic [31:0] rd);
        int               lat;
        logic [WIDTH-1:0] acc;
        busXfer(1'b0, off, 4'hF, 32'd0, rd, lat, acc);
    endtask

    task automatic wbWrite(input logic [4:0] off, input logic [3:0] sel, input logic [31:0] dat,
                           output logic [WIDTH-1:0] acc);
        logic [31:0] rd;
        int          lat;
        busXfer(1'b1, off, sel, dat, rd, lat, acc);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0]      rd;
        int               lat;
        logic [WIDTH-1:0] acc;
        busXfer(v.we, v.off, v.sel, v.wdat, rd, lat, acc);
        if (!v.we) checkOutput($sformatf("table vec%0d", idx), rd, v.expRd);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t             vecs[16];
        logic [31:0]      rd;
        int               lat;
        logic [WIDTH-1:0] v0, acc;

        vecs[0]  = '{1'b1, OFF_CTRL,   4'hF, 32'hFFFF_FFFE, 32'h0};
        vecs[1]  = '{1'b0, OFF_CTRL,   4'hF, 32'h0,         32'h00FF_FF02};
        vecs[2]  = '{1'b1, OFF_CTRL,   4'h3, 32'h0000_0001, 32'h0};
        vecs[3]  = '{1'b0, OFF_CTRL,   4'hF, 32'h0,         32'h00FF_FF02};
        vecs[4]  = '{1'b1, OFF_THRESH, 4'hF, 32'hFFFF_FFF7, 32'h0};
        vecs[5]  = '{1'b0, OFF_THRESH, 4'hF, 32'h0,         32'h0000_0007};
        vecs[6]  = '{1'b1, OFF_THRESH, 4'h1, 32'h0000_0003, 32'h0};
        vecs[7]  = '{1'b0, OFF_THRESH, 4'hF, 32'h0,         32'h0000_0007};
        vecs[8]  = '{1'b1, OFF_STATUS, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, OFF_STATUS, 4'hF, 32'h0,         32'h0000_0001};
        vecs[10] = '{1'b0, OFF_CLEAR,  4'hF, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 5'h14,      4'hF, 32'h0,         32'h0};
        vecs[12] = '{1'b1, OFF_CTRL,   4'hF, 32'h0,         32'h0};
        vecs[13] = '{1'b0, OFF_CTRL,   4'hF, 32'h0,         32'h0};
        vecs[14] = '{1'b1, OFF_THRESH, 4'hF, 32'h0,         32'h0};
        vecs[15] = '{1'b0, OFF_THRESH, 4'hF, 32'h0,         32'h0};

        checks = 0; errors = 0;
        reset = 1'b1; valueIn = 1; valueRandom = 0; modelOn = 1;
        wbBus.wbs_stb_i = 0; wbBus.wbs_cyc_i = 0; wbBus.wbs_we_i = 0;
        wbBus.wbs_sel_i = 0; wbBus.wbs_dat_i = 0; wbBus.wbs_adr_i = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset irq", 32'(irqO), 32'd0);
        checkOutput("reset level", 32'(levelO), 32'd0);
        checkOutput("reset ack", 32'(wbBus.wbs_ack_o), 32'd0);
        checkOutput("reset dat", wbBus.wbs_dat_o, 32'd0);
        busXfer(1'b0, OFF_STATUS, 4'hF, 32'd0, rd, lat, acc);
        checkOutput("reset status", rd, 32'h0000_0001);
        checkOutput("reset ack latency", 32'(lat), 32'd1);

        $display("[TB] fill to full and overflow, div 0");
        wbWrite(OFF_CTRL, 4'hF, 32'h1, v0);
        idle(8);
        wbRead(OFF_STATUS, rd);
        checkOutput("full status", rd, 32'h0000_0802);
        wbRead(OFF_STATUS, rd);
        checkOutput("overflow status", rd, 32'h0000_0806);
        wbWrite(OFF_CTRL, 4'hF, 32'h0, acc);
        for (int i = 0; i < 8; i++) begin
            wbRead(OFF_DATA, rd);
            checkOutput($sformatf("drain %0d", i), rd, 32'(v0 + WIDTH'(i + 1)));
        end
        wbRead(OFF_DATA, rd);
        checkOutput("read when empty", rd, 32'd0);
        wbRead(OFF_STATUS, rd);
        checkOutput("empty bit", 32'(rd[0]), 32'd1);
        wbWrite(OFF_CLEAR, 4'hF, 32'h0, acc);
        wbRead(OFF_STATUS, rd);
        checkOutput("status after clear", rd, 32'h0000_0001);

        $display("[TB] decimation div 3");
        wbWrite(OFF_CTRL, 4'hF, 32'h0000_0301, v0);
        idle(15);
        wbWrite(OFF_CTRL, 4'hF, 32'h0, acc);
        wbRead(OFF_STATUS, rd);
        checkOutput("div3 status", rd, 32'h0000_0400);
        for (int i = 1; i <= 4; i++) begin
            wbRead(OFF_DATA, rd);
            checkOutput($sformatf("div3 sample %0d", i), rd, 32'(v0 + WIDTH'(4 * i)));
        end

        $display("[TB] threshold interrupt");
        wbWrite(OFF_CLEAR, 4'hF, 32'h0, acc);
        wbWrite(OFF_THRESH, 4'hF, 32'h4, acc);
        wbWrite(OFF_CTRL, 4'hF, 32'h3, v0);
        idle(3);
        wbWrite(OFF_CTRL, 4'hF, 32'h2, acc);
        checkOutput("irq level 4", 32'(levelO), 32'd4);
        checkOutput("irq not yet", 32'(irqO), 32'd0);
        idle(1);
        checkOutput("irq rises", 32'(irqO), 32'd1);
        wbRead(OFF_DATA, rd);
        checkOutput("irq pop data", rd, 32'(v0 + WIDTH'(1)));
        checkOutput("irq still high", 32'(irqO), 32'd1);
        idle(1);
        checkOutput("irq falls", 32'(irqO), 32'd0);
        wbWrite(OFF_CLEAR, 4'hF, 32'h0, acc);
        wbWrite(OFF_THRESH, 4'hF, 32'h0, acc);
        wbWrite(OFF_CTRL, 4'hF, 32'h0, acc);

        $display("[TB] pop coinciding with push while full, div 1");
        wbWrite(OFF_CTRL, 4'hF, 32'h0000_0101, v0);
        idle(17);
        wbRead(OFF_DATA, rd);
        checkOutput("full pop oldest", rd, 32'(v0 + WIDTH'(2)));
        checkOutput("full pop level", 32'(levelO), 32'd8);
        wbRead(OFF_STATUS, rd);
        checkOutput("full pop status", rd, 32'h0000_0802);
        wbWrite(OFF_CTRL, 4'hF, 32'h0, acc);
        wbWrite(OFF_CLEAR, 4'hF, 32'h0, acc);

        $display("[TB] register table");
        for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

        $display("[TB] held strobe and non-hit cycles");
        idle(1);
        wbBus.wbs_stb_i = 1; wbBus.wbs_cyc_i = 1; wbBus.wbs_we_i = 0;
        wbBus.wbs_sel_i = 4'hF; wbBus.wbs_adr_i = BASE | {27'd0, OFF_STATUS};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("held ack %0d", i), 32'(wbBus.wbs_ack_o), 32'((i % 2) == 0));
        end
        wbBus.wbs_adr_i = BASE + 32'h100;
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("miss address ack", 32'(wbBus.wbs_ack_o), 32'd0);
        end
        wbBus.wbs_adr_i = BASE; wbBus.wbs_cyc_i = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("no cyc ack", 32'(wbBus.wbs_ack_o), 32'd0);
        end
        wbBus.wbs_stb_i = 0;

        $display("[TB] reset during strobe");
        idle(1);
        wbBus.wbs_stb_i = 1; wbBus.wbs_cyc_i = 1; wbBus.wbs_we_i = 1;
        wbBus.wbs_sel_i = 4'hF; wbBus.wbs_dat_i = 32'h5;
        wbBus.wbs_adr_i = BASE | {27'd0, OFF_THRESH};
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset drops ack", 32'(wbBus.wbs_ack_o), 32'd0);
        wbBus.wbs_stb_i = 0; wbBus.wbs_cyc_i = 0; wbBus.wbs_we_i = 0;
        reset = 1'b0;
        wbRead(OFF_THRESH, rd);
        checkOutput("thresh after reset", rd, 32'd0);

        $display("[TB] randomized traffic");
        valueRandom = 1;
        for (int i = 0; i < 300; i++) begin
            int          op;
            int          pick;
            logic [4:0]  off;
            logic        we;
            logic [3:0]  sel;
            logic [31:0] dat;
            op = int'($urandom_range(0, 9));
            if (op < 2) begin
                idle(int'($urandom_range(1, 4)));
            end else begin
                pick = int'($urandom_range(0, 7));
                case (pick)
                    0:       off = OFF_STATUS;
                    1, 2:    off = OFF_DATA;
                    3:       off = OFF_CTRL;
                    4:       off = OFF_CLEAR;
                    5:       off = OFF_THRESH;
                    6:       off = 5'h14;
                    default: off = 5'h02;
                endcase
                we  = ($urandom_range(0, 2) == 0);
                sel = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
                dat = $urandom;
                if (off == OFF_CTRL)   dat = {16'h0000, 8'($urandom_range(0, 3)), dat[7:0]};
                if (off == OFF_THRESH) dat[3:0] = 4'($urandom_range(0, 8));
                busXfer(we, off, sel, dat, rd, lat, acc);
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_sample_fifo.md
Name: fib_sample_fifo

Overview:
- Capture stage directly downstream of the fibonacci generator; samples its WIDTH-bit value bus into a small FIFO at a programmable decimation rate.
- Firmware drains the FIFO over a Wishbone slave window.
- Raises an interrupt on a level threshold or on overflow.
- Sits beside the existing control window in the user project; value_i is driven by the same bus that feeds io_out[37:8].

Parameters:
WIDTH, 30, width of sampled value (must be <= 32)
DEPTH, 8, FIFO entries (power of 2, 2..8)
BASE_ADDRESS, 32'h3000_0100, window base; decode on wbs_adr_i[31:5] == BASE_ADDRESS[31:5]

Ports:
wb_clk_i  in  1  clock
reset  in  1  synchronous, active-high
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  address
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
value_i  in  WIDTH  generator output
irq_o  out  1  interrupt, level
level_o  out  4  current FIFO count

Behaviour:
- Reset: reset, synchronous, active-high; clock wb_clk_i. Reset zeroes wbs_ack_o, wbs_dat_o, irq_o, level_o, pointers, count, overflow, CTRL, THRESH, and the divider counter.
- Reset mid-transaction drops the transaction: no ack and no side effect.
- Registers, offset adr[4:0]:
  - 0x00 STATUS (RO): bit0 empty, bit1 full, bit2 overflow (sticky), bits[11:8] count, rest 0.
  - 0x04 DATA (RO, pop): returns zero-extended head entry and pops it. If empty, returns 0 with no pop.
  - 0x08 CTRL (RW): bit0 enable, bit1 irq_en, bits[23:8] div. Other bits read 0.
  - 0x0C CLEAR (WO): write flushes FIFO (pointers and count to 0) and clears overflow. Reads return 0.
  - 0x10 THRESH (RW): bits[3:0] level threshold.
  - Unmapped or read-only writes: acked, ignored. Unmapped reads: 0.
- Handshake: hit = stb & cyc & address match.
  - wbs_ack_o <= hit & !wbs_ack_o, i.e. a one-cycle pulse; a held strobe gets an ack every other cycle.
  - Read data, pop and register writes all occur on the same edge that asserts ack.
  - wbs_dat_o holds its last value otherwise.
  - Non-hit cycles produce no ack.
- Writes take effect only when wbs_sel_i == 4'hF; otherwise acked and ignored.
- Decimation: counter cnt runs only while enable = 1.
  - When cnt == div: sample strobe, cnt <= 0; else cnt <= cnt+1.
  - div = 0 samples every cycle.
  - Any CTRL write or enable = 0 forces cnt to 0.
- Push on sample strobe writes value_i at the strobe edge.
- Full FIFO:
  - Push while full with no pop: value discarded, overflow set.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
- Empty FIFO: push and pop in the same cycle while empty returns 0 (no bypass); the push is stored, count becomes 1.
- CLEAR coincident with a push: CLEAR wins; the sample is dropped and overflow stays 0.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- irq_o is registered, one cycle after the condition: irq_en & ((THRESH != 0 & count >= THRESH) | overflow).
- level_o = count (combinational from register).

Test Plan:
- Reset, read STATUS -> 0x0000_0001, ack exactly one cycle after strobe, wbs_dat_o 0, irq_o 0.
- value_i incrementing 1,2,3…, write CTRL=0x1 (div 0). After 8 samples STATUS -> 0x0000_0802; 2 more cycles -> 0x0000_0806. Eight DATA reads return the first 8 captured values in order. Ninth read -> 0 with STATUS bit0 = 1.
- CTRL=0x0000_0301 (div 3) for 16 cycles -> count 4, samples spaced exactly 4 values apart.
- THRESH=4, CTRL=0x3 -> irq_o rises one cycle after count reaches 4. One DATA read -> irq_o falls one cycle later.
- Full FIFO, DATA read coinciding with a sample strobe -> count stays 8, overflow stays 0, returned value is the oldest entry.
- CTRL write with sel=4'h3 -> acked, CTRL unchanged. CLEAR write -> STATUS 0x0000_0001. Reset asserted during a strobe -> no ack.
